// File: rtl/vtx1_mem_arbiter_pkg.sv
// Shared types and default widths for the memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vtx1_mem_arbiter_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int VLIW_WIDTH = 128;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DATA  = 2'd1,
        ARB_FETCH = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    // Number of bits needed to hold the values 0..max inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vtx1_fetch_assembler.sv
// Collects FETCH_BEATS consecutive memory words into one VLIW bundle.
// Latency: each accepted beat lands in the bundle register on the next edge.
// Backpressure: none; beats are written only when beat_valid is asserted.
module vtx1_fetch_assembler #(
    parameter int DW          = 32,
    parameter int IW          = 128,
    parameter int FETCH_BEATS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          beat_valid,
    input  logic [DW-1:0] beat_data,
    output logic          last_beat,
    output logic [IW-1:0] bundle
);

    localparam int CW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;

    logic [CW-1:0] beat_cnt;

    assign last_beat = (beat_cnt == CW'(FETCH_BEATS - 1));

    // Load clears the bundle so an aborted fetch returns all zeros; each beat fills its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            bundle   <= '0;
        end else if (load) begin
            beat_cnt <= '0;
            bundle   <= '0;
        end else if (beat_valid) begin
            bundle[int'(beat_cnt) * DW +: DW] <= beat_data;
            beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vtx1_mem_arbiter.sv
// Shares one word memory port between instruction fetch (multi-beat bundle) and data (single beat).
// Latency: with mem_ready high, data completes 2 cycles after request, fetch FETCH_BEATS+1 cycles.
// Backpressure: mem_ready stalls a beat up to TIMEOUT_CYCLES; perf counters only with VTX1_ARB_PERF_EN.
module vtx1_mem_arbiter
    import vtx1_mem_arbiter_pkg::*;
#(
    parameter int DW             = WORD_WIDTH,
    parameter int IW             = VLIW_WIDTH,
    parameter int FETCH_BEATS    = VLIW_WIDTH / WORD_WIDTH,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [DW-1:0] if_addr,
    output logic [IW-1:0] if_data,
    output logic          if_ready,
    input  logic          d_req,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_we,
    input  logic          d_oe,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_oe,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          timeout,
    output logic          busy,
    output logic [31:0]   perf_if_grants,
    output logic [31:0]   perf_d_grants,
    output logic [31:0]   perf_wait_cycles
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam int SW = cnt_width(STARVE_LIMIT);

    arb_state_t    state;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] starve_cnt;

    logic hs;
    logic tmo_hit;
    logic force_fetch;
    logic grant_d;
    logic grant_if;
    logic last_beat;

    assign hs          = mem_req && mem_ready;
    assign tmo_hit     = mem_req && !mem_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign force_fetch = if_req && (starve_cnt == SW'(STARVE_LIMIT));
    assign grant_d     = (state == ARB_IDLE) && d_req && !force_fetch;
    assign grant_if    = (state == ARB_IDLE) && if_req && !grant_d;

    vtx1_fetch_assembler #(
        .DW          (DW),
        .IW          (IW),
        .FETCH_BEATS (FETCH_BEATS)
    ) u_fetch_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (grant_if || ((state == ARB_FETCH) && tmo_hit)),
        .beat_valid ((state == ARB_FETCH) && hs),
        .beat_data  (mem_rdata),
        .last_beat  (last_beat),
        .bundle     (if_data)
    );

    // Arbitration FSM: grants in IDLE, drives the memory beats, and pulses completion from DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            tmo_cnt    <= '0;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            d_rdata    <= '0;
            d_ready    <= 1'b0;
            if_ready   <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            d_ready  <= 1'b0;
            if_ready <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    tmo_cnt <= '0;
                    if (grant_d) begin
                        state     <= ARB_DATA;
                        busy      <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_we    <= d_we;
                        mem_oe    <= d_oe && !d_we;
                        // A request with neither strobe never touches memory.
                        mem_req   <= d_we || d_oe;
                        if (if_req && (starve_cnt != SW'(STARVE_LIMIT)))
                            starve_cnt <= starve_cnt + SW'(1);
                    end else if (grant_if) begin
                        state      <= ARB_FETCH;
                        busy       <= 1'b1;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        mem_we     <= 1'b0;
                        mem_oe     <= 1'b1;
                        mem_req    <= 1'b1;
                        starve_cnt <= '0;
                    end
                end
                ARB_DATA: begin
                    if (!mem_req || hs || tmo_hit) begin
                        d_rdata <= (hs && !mem_we) ? mem_rdata : '0;
                        timeout <= tmo_hit;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_oe  <= 1'b0;
                        d_ready <= 1'b1;
                        state   <= ARB_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ARB_FETCH: begin
                    if (hs) begin
                        tmo_cnt <= '0;
                        if (last_beat) begin
                            mem_req  <= 1'b0;
                            mem_oe   <= 1'b0;
                            if_ready <= 1'b1;
                            state    <= ARB_DONE;
                        end else begin
                            // Address wraps naturally at 2^DW.
                            mem_addr <= mem_addr + DW'(1);
                        end
                    end else if (tmo_hit) begin
                        mem_req  <= 1'b0;
                        mem_oe   <= 1'b0;
                        timeout  <= 1'b1;
                        if_ready <= 1'b1;
                        state    <= ARB_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VTX1_ARB_PERF_EN
    logic [31:0] if_grant_cnt;
    logic [31:0] d_grant_cnt;
    logic [31:0] wait_cnt;
    logic        d_served;
    logic        if_served;

    // The owner in DONE is the one whose ready pulse is up.
    assign d_served  = grant_d || (state == ARB_DATA) || d_ready;
    assign if_served = grant_if || (state == ARB_FETCH) || if_ready;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_grant_cnt <= '0;
            d_grant_cnt  <= '0;
            wait_cnt     <= '0;
        end else begin
            if (grant_if)
                if_grant_cnt <= if_grant_cnt + 32'd1;
            if (grant_d)
                d_grant_cnt <= d_grant_cnt + 32'd1;
            if ((d_req && !d_served) || (if_req && !if_served))
                wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign perf_if_grants   = if_grant_cnt;
    assign perf_d_grants    = d_grant_cnt;
    assign perf_wait_cycles = wait_cnt;
`else
    assign perf_if_grants   = '0;
    assign perf_d_grants    = '0;
    assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_vtx1_mem_arbiter.sv
// Self-checking bench for vtx1_mem_arbiter: scoreboard of expected beats and completions.
// Latency: n/a.
// Backpressure: memory model stalls mem_ready randomly but never long enough to time out, except when asked.
module tb_vtx1_mem_arbiter;

    localparam int DW = 32;
    localparam int IW = 128;
    localparam int FB = 4;
    localparam int SL = 4;
    localparam int TO = 8;
    localparam int ND = 10;
    localparam int NF = 3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        bit          oe;
    } beat_t;

    typedef struct {
        bit           is_f;
        logic [127:0] dat;
    } resp_t;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic [IW-1:0] if_data;
    logic          if_ready;
    logic          d_req;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_we;
    logic          d_oe;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_req;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_oe;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          timeout;
    logic          busy;
    logic [31:0]   perf_if_grants;
    logic [31:0]   perf_d_grants;
    logic [31:0]   perf_wait_cycles;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    mem_mode = 2;
    int    low_run  = 0;
    bit    mon_en   = 0;
    int    tmo_seen = 0;
    int    tmo_exp  = 0;
    int    nfg      = 0;
    int    ndg      = 0;
    int    model_sc = 0;
    beat_t beat_q[$];
    resp_t resp_q[$];
    beat_t mb;
    resp_t mr;

    logic [31:0] dl_addr[ND];
    logic [31:0] dl_wdata[ND];
    bit          dl_we[ND];
    bit          dl_oe[ND];
    logic [31:0] fl_addr[NF];

    vtx1_mem_arbiter #(
        .DW             (DW),
        .IW             (IW),
        .FETCH_BEATS    (FB),
        .STARVE_LIMIT   (SL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_data          (if_data),
        .if_ready         (if_ready),
        .d_req            (d_req),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_we             (d_we),
        .d_oe             (d_oe),
        .d_rdata          (d_rdata),
        .d_ready          (d_ready),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_we           (mem_we),
        .mem_oe           (mem_oe),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready),
        .timeout          (timeout),
        .busy             (busy),
        .perf_if_grants   (perf_if_grants),
        .perf_d_grants    (perf_d_grants),
        .perf_wait_cycles (perf_wait_cycles)
    );

    // Memory contents: every word reads back as its own address, except 0x10 which holds 0x5A.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'h5A : a;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory ready driver: 0 = random with at most 3 stall cycles, 1 = never ready, else always ready.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_mode == 0) begin
                if (low_run >= 3 || $urandom_range(0, 3) != 0) begin
                    mem_ready = 1'b1;
                    low_run   = 0;
                end else begin
                    mem_ready = 1'b0;
                    low_run++;
                end
            end else if (mem_mode == 1) begin
                mem_ready = 1'b0;
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Transaction-level expectation: which memory beats a request produces and what it returns.
    function automatic void push_exp(input bit is_f, input logic [31:0] a, input logic [31:0] wd,
                                     input bit we, input bit oe);
        resp_t       r;
        beat_t       b;
        logic [31:0] ak;
        r.is_f = is_f;
        r.dat  = '0;
        if (is_f) begin
            nfg++;
            for (int k = 0; k < FB; k++) begin
                ak = a + 32'(k);
                b  = '{ak, 32'h0, 1'b0, 1'b1};
                beat_q.push_back(b);
                r.dat[k*32 +: 32] = mem_fn(ak);
            end
        end else begin
            ndg++;
            if (we) begin
                b = '{a, wd, 1'b1, 1'b0};
                beat_q.push_back(b);
            end else if (oe) begin
                b = '{a, 32'h0, 1'b0, 1'b1};
                beat_q.push_back(b);
                r.dat = {96'h0, mem_fn(a)};
            end
        end
        resp_q.push_back(r);
    endfunction

    task automatic drive_txn(input bit is_f, input logic [31:0] a, input logic [31:0] wd,
                             input bit we, input bit oe, output int lat);
        int start;
        bit got;
        @(posedge clk);
        #1;
        if (is_f) begin
            if_req  = 1'b1;
            if_addr = a;
        end else begin
            d_req   = 1'b1;
            d_addr  = a;
            d_wdata = wd;
            d_we    = we;
            d_oe    = oe;
        end
        start = cyc;
        got   = 0;
        lat   = -1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (is_f ? if_ready : d_ready) begin
                got = 1;
                lat = cyc - start;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_ready_wait: no completion in 1000 cycles, required one", is_f ? "if" : "d");
        end
    endtask

    task automatic release_req(input bit is_f);
        @(posedge clk);
        #1;
        if (is_f) if_req = 1'b0;
        else      d_req  = 1'b0;
    endtask

    task automatic issue_one(input bit is_f, input logic [31:0] a, input logic [31:0] wd,
                             input bit we, input bit oe, output int lat);
        if (is_f) model_sc = 0;
        push_exp(is_f, a, wd, we, oe);
        drive_txn(is_f, a, wd, we, oe, lat);
        release_req(is_f);
    endtask

    // Monitor: every memory handshake and every completion is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (mem_req && mem_ready) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: handshake at addr %h, required none", mem_addr);
                end else begin
                    mb = beat_q.pop_front();
                    chk("beat_addr", 128'(mem_addr), 128'(mb.addr));
                    chk("beat_we", 128'(mem_we), 128'(mb.we));
                    chk("beat_oe", 128'(mem_oe), 128'(mb.oe));
                    if (mb.we) chk("beat_wdata", 128'(mem_wdata), 128'(mb.wdata));
                end
            end
            if (d_ready || if_ready) begin
                if (resp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: d_ready=%0d if_ready=%0d, required no completion",
                             d_ready, if_ready);
                end else begin
                    mr = resp_q.pop_front();
                    chk("resp_kind", 128'(if_ready), 128'(mr.is_f));
                    chk("ready_exclusive", 128'(d_ready && if_ready), 128'(0));
                    if (d_ready) chk("d_rdata", 128'(d_rdata), mr.dat);
                    else         chk("if_data", if_data, mr.dat);
                end
            end
            if (timeout) tmo_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        int hs;
        bit got;
        bit rdy;
        int nd;
        int nf;
        int i_d;
        int i_f;
        int kind;
        logic [31:0] a;

        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_we    = 1'b0;
        d_oe    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset_ctrl", 128'({mem_req, mem_we, mem_oe, d_ready, if_ready, timeout, busy}), 128'(0));
        chk("reset_mem_addr", 128'(mem_addr), 128'(0));
        chk("reset_if_data", if_data, 128'(0));
        chk("reset_d_rdata", 128'(d_rdata), 128'(0));
        mon_en = 1;

        // Directed single-requester cases with memory always ready.
        mem_mode = 2;
        issue_one(0, 32'h10, 32'h0, 0, 1, lat);
        chk("data_read_latency", 128'(lat), 128'(2));
        issue_one(1, 32'h20, 32'h0, 0, 0, lat);
        chk("fetch_latency", 128'(lat), 128'(FB + 1));
        issue_one(1, 32'hFFFF_FFFE, 32'h0, 0, 0, lat);
        chk("fetch_wrap_latency", 128'(lat), 128'(FB + 1));
        issue_one(0, 32'h33, 32'hDEAD_BEEF, 1, 1, lat);
        chk("data_write_latency", 128'(lat), 128'(2));
        issue_one(0, 32'h44, 32'h0, 0, 0, lat);

        // Randomized single transactions with memory stalls.
        mem_mode = 0;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 4);
            a    = $urandom;
            if (kind == 0 && $urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            issue_one(kind == 0, a, $urandom, kind == 2 || kind == 4, kind == 1 || kind == 4, lat);
        end

        // Both requesters held continuously: data wins until fetch has waited STARVE_LIMIT grants.
        for (int i = 0; i < ND; i++) begin
            dl_addr[i]  = $urandom;
            dl_wdata[i] = $urandom;
            dl_we[i]    = $urandom_range(0, 1) == 1;
            dl_oe[i]    = $urandom_range(0, 3) != 0;
        end
        for (int i = 0; i < NF; i++) fl_addr[i] = $urandom;
        nd = ND; nf = NF; i_d = 0; i_f = 0;
        while (nd > 0 || nf > 0) begin
            if (nd > 0 && !(nf > 0 && model_sc == SL)) begin
                push_exp(0, dl_addr[i_d], dl_wdata[i_d], dl_we[i_d], dl_oe[i_d]);
                i_d++;
                nd--;
                if (nf > 0 && model_sc < SL) model_sc++;
            end else begin
                push_exp(1, fl_addr[i_f], 32'h0, 0, 0);
                i_f++;
                nf--;
                model_sc = 0;
            end
        end
        fork
            begin
                int l1;
                for (int i = 0; i < ND; i++) drive_txn(0, dl_addr[i], dl_wdata[i], dl_we[i], dl_oe[i], l1);
                release_req(0);
            end
            begin
                int l2;
                for (int i = 0; i < NF; i++) drive_txn(1, fl_addr[i], 32'h0, 0, 0, l2);
                release_req(1);
            end
        join

        // Beat timeout on a data read that memory never acknowledges.
        @(negedge clk);
        mem_mode = 1;
        push_exp(0, 32'h40, 32'h0, 0, 1);
        resp_q[resp_q.size() - 1].dat = '0;
        void'(beat_q.pop_back());
        tmo_exp++;
        @(posedge clk);
        #1;
        d_req = 1'b1; d_addr = 32'h40; d_we = 1'b0; d_oe = 1'b1;
        cnt = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (mem_req) cnt++;
            if (d_ready) begin
                got = 1;
                chk("timeout_pulse", 128'(timeout), 128'(1));
            end
        end
        chk("timeout_ready_seen", 128'(got), 128'(1));
        chk("timeout_mem_req_cycles", 128'(cnt), 128'(TO));
        release_req(0);
        @(negedge clk);
        chk("timeout_busy_after", 128'(busy), 128'(0));
        mem_mode = 2;

        // Asynchronous reset in the middle of beat 2 of a fetch.
        mon_en = 0;
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'h100;
        hs = 0;
        for (int i = 0; i < 50 && hs < 2; i++) begin
            @(negedge clk);
            if (mem_req && mem_ready) hs++;
        end
        @(posedge clk);
        #2;
        chk("rst_pre_mem_req", 128'(mem_req), 128'(1));
        chk("rst_pre_mem_addr", 128'(mem_addr), 128'(32'h102));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req_drop", 128'(mem_req), 128'(0));
        chk("rst_busy_drop", 128'(busy), 128'(0));
        chk("rst_if_data_clear", if_data, 128'(0));
        if_req = 1'b0;
        rdy = 0;
        repeat (3) begin
            @(negedge clk);
            rdy = rdy | if_ready;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            rdy = rdy | if_ready;
        end
        chk("rst_no_if_ready", 128'(rdy), 128'(0));
        beat_q.delete();
        resp_q.delete();
        nfg = 0; ndg = 0; model_sc = 0; tmo_seen = 0; tmo_exp = 0;
        mon_en = 1;
        issue_one(1, 32'h100, 32'h0, 0, 0, lat);
        chk("post_reset_fetch_latency", 128'(lat), 128'(FB + 1));
        issue_one(0, 32'h10, 32'h0, 0, 1, lat);

        repeat (3) @(negedge clk);
        chk("beat_q_drained", 128'(beat_q.size()), 128'(0));
        chk("resp_q_drained", 128'(resp_q.size()), 128'(0));
        chk("timeout_count", 128'(tmo_seen), 128'(tmo_exp));
`ifdef VTX1_ARB_PERF_EN
        chk("perf_if_grants", 128'(perf_if_grants), 128'(nfg));
        chk("perf_d_grants", 128'(perf_d_grants), 128'(ndg));
`else
        chk("perf_if_grants_off", 128'(perf_if_grants), 128'(0));
        chk("perf_d_grants_off", 128'(perf_d_grants), 128'(0));
        chk("perf_wait_off", 128'(perf_wait_cycles), 128'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
